// File: rtl/am2910_issue_ctl.sv
// ---------------------------------------------------------------------------
// am2910_issue_ctl
//
// Issue controller that sits between a pipeline register, an external
// Am2910-style microprogram sequencer and an asynchronous control store.
// The controller owns the 24-bit pipeline register (pl) and decides every
// cycle what to present to the sequencer: the pipelined instruction, a
// forced "hold" (CONT without increment), an interrupt call, or the idle
// JZ pattern that parks the sequencer at microaddress 0.
//
// pl layout:
//    [3:0]   op        sequencer instruction
//    [15:4]  br        branch / D field
//    [18:16] csel      condition select into cond_in
//    [19]    cpol      condition polarity (1 = test for a low condition)
//    [20]    ccen_bar  condition-code enable (active low)
//    [21]    rld_bar   counter load (active low)
//    [23:22] ctl       datapath control field
//
// Ports:
//    clk           sole clock, all state on its rising edge
//    rst           synchronous active-high reset
//    start         begin / restart execution from microaddress 0
//    halt_req      stop at the next microinstruction boundary
//    rom_addr      control-store address (= seq_y, combinational)
//    rom_data      control-store read data at rom_addr
//    seq_i         sequencer instruction
//    seq_ccen_bar  sequencer condition enable (active low)
//    seq_cc_bar    sequencer condition input (active low)
//    seq_rld_bar   sequencer counter load (active low)
//    seq_ci        sequencer microPC carry-in
//    seq_d         sequencer D input
//    seq_y         sequencer Y output
//    seq_full      sequencer stack holds 5 entries
//    cond_in       status conditions
//    irq_req       level-sensitive interrupt request
//    irq_vec       interrupt vector address
//    irq_ack       one-cycle pulse when the interrupt is taken
//    ctl_out       datapath control field
//    busy          FETCH or RUN
//    halted        HALT
//    stk_err       sticky stack-guard error
// ---------------------------------------------------------------------------
module am2910_issue_ctl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_req,
   output logic [11:0] rom_addr,
   input  logic [23:0] rom_data,
   output logic [3:0]  seq_i,
   output logic        seq_ccen_bar,
   output logic        seq_cc_bar,
   output logic        seq_rld_bar,
   output logic        seq_ci,
   output logic [11:0] seq_d,
   input  logic [11:0] seq_y,
   input  logic        seq_full,
   input  logic [7:0]  cond_in,
   input  logic        irq_req,
   input  logic [11:0] irq_vec,
   output logic        irq_ack,
   output logic [1:0]  ctl_out,
   output logic        busy,
   output logic        halted,
   output logic        stk_err
);

   // Controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   // Sequencer opcodes the controller needs to recognise or generate
   localparam logic [3:0] OP_JZ   = 4'd0;
   localparam logic [3:0] OP_CJS  = 4'd1;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_JSRP = 4'd5;
   localparam logic [3:0] OP_CONT = 4'd14;

   logic [1:0]  state_q, state_d;
   logic [23:0] pl_q, pl_d;
   logic        stk_err_q, stk_err_d;

   // Pipeline register fields
   logic [3:0]  pl_op;
   logic [11:0] pl_br;
   logic [2:0]  pl_csel;
   logic        pl_cpol;
   logic        pl_ccen_bar;
   logic        pl_rld_bar;
   logic [1:0]  pl_ctl;

   assign pl_op       = pl_q[3:0];
   assign pl_br       = pl_q[15:4];
   assign pl_csel     = pl_q[18:16];
   assign pl_cpol     = pl_q[19];
   assign pl_ccen_bar = pl_q[20];
   assign pl_rld_bar  = pl_q[21];
   assign pl_ctl      = pl_q[23:22];

   // The control store is addressed straight from the sequencer.
   assign rom_addr = seq_y;

   // Condition select as a one-hot AND-OR so the mux stays flat.
   logic [7:0] cond_hit;
   logic       cond_sel;

   for (genvar gi = 0; gi < 8; gi++) begin : g_cond_sel
      assign cond_hit[gi] = (pl_csel == 3'(gi)) & cond_in[gi];
   end

   assign cond_sel = |cond_hit;

   // Instructions that push the sequencer stack: executing one while the
   // stack is already full would silently overwrite the top entry.
   logic push_op;
   logic guard_hit;
   logic irq_take;

   assign push_op   = (pl_op == OP_CJS) | (pl_op == OP_PUSH) | (pl_op == OP_JSRP);
   assign guard_hit = push_op & seq_full;
   // Interrupts are only taken on a CONT so the return address is simply
   // the microPC; with a full stack the call would have nowhere to go, so
   // the request waits (no error) until room appears.
   assign irq_take  = irq_req & (pl_op == OP_CONT) & ~seq_full;

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      // Idle pattern: JZ with everything inactive parks Y at 0.
      seq_i        = OP_JZ;
      seq_ci       = 1'b0;
      seq_d        = 12'h000;
      seq_ccen_bar = 1'b1;
      seq_cc_bar   = 1'b1;
      seq_rld_bar  = 1'b1;
      ctl_out      = 2'b00;
      irq_ack      = 1'b0;
      state_d      = state_q;
      pl_d         = pl_q;
      stk_err_d    = stk_err_q;

      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_FETCH;
               end
            end

            ST_FETCH: begin
               // Y is 0 here, so this captures microword 0.
               pl_d    = rom_data;
               state_d = ST_RUN;
            end

            ST_RUN: begin
               if (halt_req) begin
                  seq_i   = OP_CONT;
                  state_d = ST_HALT;
               end else if (guard_hit) begin
                  seq_i     = OP_CONT;
                  stk_err_d = 1'b1;
                  state_d   = ST_HALT;
               end else if (irq_take) begin
                  // Unconditional CJS to the vector; the sequencer pushes
                  // its microPC, which already points past the current word.
                  seq_i   = OP_CJS;
                  seq_d   = irq_vec;
                  seq_ci  = 1'b1;
                  ctl_out = pl_ctl;
                  irq_ack = 1'b1;
                  pl_d    = rom_data;
               end else begin
                  seq_i        = pl_op;
                  seq_d        = pl_br;
                  seq_ci       = 1'b1;
                  seq_ccen_bar = pl_ccen_bar;
                  seq_rld_bar  = pl_rld_bar;
                  seq_cc_bar   = ~(cond_sel ^ pl_cpol);
                  ctl_out      = pl_ctl;
                  pl_d         = rom_data;
               end
            end

            ST_HALT: begin
               // CONT with no carry keeps Y frozen while stopped.
               seq_i = OP_CONT;
               if (start) begin
                  stk_err_d = 1'b0;
                  state_d   = ST_FETCH;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pl_q      <= 24'h000000;
         stk_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pl_q      <= pl_d;
         stk_err_q <= stk_err_d;
      end
   end

   // Status flags are masked during reset so the cycle in which reset is
   // asserted already looks like IDLE to the outside world.
   assign busy    = ~rst & ((state_q == ST_FETCH) | (state_q == ST_RUN));
   assign halted  = ~rst & (state_q == ST_HALT);
   assign stk_err = ~rst & stk_err_q;

endmodule

// File: tb/tb_am2910_issue_ctl.sv
// ---------------------------------------------------------------------------
// tb_am2910_issue_ctl
//
// Closed-loop bench: a behavioural Am2910 sequencer and a 4K x 24 control
// store surround the controller. A reference model (controller rules plus
// its own copy of the sequencer) predicts every cycle's outputs, including
// the address the control store will see; predictions go into a scoreboard
// queue that a negedge monitor drains and compares.
// ---------------------------------------------------------------------------
module tb_am2910_issue_ctl;

   typedef struct packed {
      logic [11:0]      upc;
      logic [11:0]      r;
      logic [2:0]       sp;
      logic [4:0][11:0] stk;
   } seq_st_t;

   typedef struct packed {
      logic [11:0] addr;
      logic [3:0]  i;
      logic [11:0] d;
      logic        ccen_b;
      logic        cc_b;
      logic        rld_b;
      logic        ci;
      logic [1:0]  ctl;
      logic        ack;
      logic        busy;
      logic        halted;
      logic        stk_err;
   } obs_t;

   typedef enum int {M_IDLE, M_FETCH, M_RUN, M_HALT} mstate_t;

   logic        clk = 1'b0;
   logic        rst, start, halt_req, irq_req, full_force;
   logic [7:0]  cond_in;
   logic [11:0] irq_vec;
   logic [11:0] rom_addr, seq_d, seq_y;
   logic [23:0] rom_data;
   logic [3:0]  seq_i;
   logic        seq_ccen_bar, seq_cc_bar, seq_rld_bar, seq_ci, seq_full;
   logic        irq_ack, busy, halted, stk_err;
   logic [1:0]  ctl_out;

   logic [23:0] rom [4096];

   int vec_cnt = 0;
   int err_cnt = 0;
   int txn     = 0;

   always #5 clk = ~clk;

   am2910_issue_ctl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .halt_req     (halt_req),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .seq_i        (seq_i),
      .seq_ccen_bar (seq_ccen_bar),
      .seq_cc_bar   (seq_cc_bar),
      .seq_rld_bar  (seq_rld_bar),
      .seq_ci       (seq_ci),
      .seq_d        (seq_d),
      .seq_y        (seq_y),
      .seq_full     (seq_full),
      .cond_in      (cond_in),
      .irq_req      (irq_req),
      .irq_vec      (irq_vec),
      .irq_ack      (irq_ack),
      .ctl_out      (ctl_out),
      .busy         (busy),
      .halted       (halted),
      .stk_err      (stk_err)
   );

   // ---------------- behavioural Am2910 ----------------
   function automatic logic [11:0] seq_tos(input seq_st_t s);
      if (s.sp == 3'd0) return 12'h000;
      return s.stk[s.sp - 3'd1];
   endfunction

   function automatic seq_st_t seq_push(input seq_st_t s);
      seq_st_t n;
      n = s;
      if (s.sp < 3'd5) begin
         n.stk[s.sp] = s.upc;
         n.sp        = s.sp + 3'd1;
      end else begin
         n.stk[4] = s.upc;
      end
      return n;
   endfunction

   function automatic seq_st_t seq_pop(input seq_st_t s);
      seq_st_t n;
      n = s;
      if (s.sp != 3'd0) n.sp = s.sp - 3'd1;
      return n;
   endfunction

   function automatic logic [11:0] seq_y_f(input seq_st_t s, input logic [3:0] i,
                                           input logic ccen_b, input logic cc_b,
                                           input logic [11:0] d);
      logic        pass, rz;
      logic [11:0] tos;
      pass = ccen_b | ~cc_b;
      rz   = (s.r == 12'h000);
      tos  = seq_tos(s);
      case (i)
         4'd0:                      return 12'h000;
         4'd1, 4'd3, 4'd6, 4'd11:   return pass ? d : s.upc;
         4'd2:                      return d;
         4'd5, 4'd7:                return pass ? d : s.r;
         4'd8:                      return rz ? s.upc : tos;
         4'd9:                      return rz ? s.upc : d;
         4'd10:                     return pass ? tos : s.upc;
         4'd13:                     return pass ? s.upc : tos;
         4'd15:                     return pass ? s.upc : (rz ? d : tos);
         default:                   return s.upc;
      endcase
   endfunction

   function automatic seq_st_t seq_nx_f(input seq_st_t s, input logic [3:0] i,
                                        input logic ccen_b, input logic cc_b,
                                        input logic rld_b, input logic ci,
                                        input logic [11:0] d);
      seq_st_t     n;
      logic        pass, rz;
      logic [11:0] y;
      pass = ccen_b | ~cc_b;
      rz   = (s.r == 12'h000);
      y    = seq_y_f(s, i, ccen_b, cc_b, d);
      n    = s;
      case (i)
         4'd0:                 n.sp = 3'd0;
         4'd1:                 if (pass) n = seq_push(n);
         4'd4, 4'd5:           n = seq_push(n);
         4'd8:                 if (rz) n = seq_pop(n);
         4'd10, 4'd11, 4'd13:  if (pass) n = seq_pop(n);
         4'd15:                if (rz || pass) n = seq_pop(n);
         default: ;
      endcase
      if (!rld_b || i == 4'd12 || (i == 4'd4 && pass))
         n.r = d;
      else if ((i == 4'd8 || i == 4'd9 || i == 4'd15) && !rz)
         n.r = s.r - 12'd1;
      n.upc = y + {11'b0, ci};
      return n;
   endfunction

   // Environment sequencer, driven by the DUT
   seq_st_t env_q = '0;

   always @(posedge clk)
      env_q <= seq_nx_f(env_q, seq_i, seq_ccen_bar, seq_cc_bar, seq_rld_bar, seq_ci, seq_d);

   always_comb begin
      seq_y    = seq_y_f(env_q, seq_i, seq_ccen_bar, seq_cc_bar, seq_d);
      seq_full = (env_q.sp == 3'd5) || full_force;
   end

   assign rom_data = rom[rom_addr];

   // ---------------- reference model ----------------
   mstate_t     m_st  = M_IDLE;
   logic [23:0] m_pl  = '0;
   logic        m_err = 1'b0;
   seq_st_t     m_seq = '0;
   obs_t        sb [$];

   function automatic logic [23:0] mk(input logic [3:0] op, input logic [11:0] br,
                                      input logic [2:0] csel, input logic cpol,
                                      input logic ccen_b, input logic rld_b,
                                      input logic [1:0] ctl);
      return {ctl, rld_b, ccen_b, cpol, csel, br, op};
   endfunction

   task automatic eval_push();
      obs_t        e;
      logic [11:0] y;
      logic [3:0]  op;
      logic        full, load, set_err, clr_err;
      mstate_t     nst;
      op      = m_pl[3:0];
      full    = (m_seq.sp == 3'd5) || full_force;
      e       = '0;
      e.ccen_b = 1'b1;
      e.cc_b   = 1'b1;
      e.rld_b  = 1'b1;
      e.stk_err = m_err && !rst;
      load    = 1'b0;
      set_err = 1'b0;
      clr_err = 1'b0;
      nst     = m_st;
      if (rst) begin
         nst = M_IDLE;
      end else begin
         case (m_st)
            M_IDLE:  if (start) nst = M_FETCH;
            M_FETCH: begin
               e.busy = 1'b1;
               load   = 1'b1;
               nst    = M_RUN;
            end
            M_RUN: begin
               e.busy = 1'b1;
               if (halt_req) begin
                  e.i = 4'd14;
                  nst = M_HALT;
               end else if ((op == 4'd1 || op == 4'd4 || op == 4'd5) && full) begin
                  e.i     = 4'd14;
                  set_err = 1'b1;
                  nst     = M_HALT;
               end else if (irq_req && op == 4'd14 && !full) begin
                  e.i   = 4'd1;
                  e.d   = irq_vec;
                  e.ci  = 1'b1;
                  e.ctl = m_pl[23:22];
                  e.ack = 1'b1;
                  load  = 1'b1;
               end else begin
                  e.i      = op;
                  e.d      = m_pl[15:4];
                  e.ci     = 1'b1;
                  e.ccen_b = m_pl[20];
                  e.rld_b  = m_pl[21];
                  e.ctl    = m_pl[23:22];
                  e.cc_b   = !(cond_in[m_pl[18:16]] ^ m_pl[19]);
                  load     = 1'b1;
               end
            end
            default: begin
               e.i      = 4'd14;
               e.halted = 1'b1;
               if (start) begin
                  clr_err = 1'b1;
                  nst     = M_FETCH;
               end
            end
         endcase
      end
      y      = seq_y_f(m_seq, e.i, e.ccen_b, e.cc_b, e.d);
      e.addr = y;
      m_seq  = seq_nx_f(m_seq, e.i, e.ccen_b, e.cc_b, e.rld_b, e.ci, e.d);
      if (rst) begin
         m_pl  = '0;
         m_err = 1'b0;
      end else begin
         if (load)    m_pl  = rom[y];
         if (set_err) m_err = 1'b1;
         if (clr_err) m_err = 1'b0;
      end
      m_st = nst;
      sb.push_back(e);
   endtask

   // ---------------- monitor ----------------
   obs_t mon_e, mon_a;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_a = {rom_addr, seq_i, seq_d, seq_ccen_bar, seq_cc_bar, seq_rld_bar,
                  seq_ci, ctl_out, irq_ack, busy, halted, stk_err};
         vec_cnt++;
         txn++;
         if (mon_a !== mon_e) begin
            err_cnt++;
            $display("FAIL txn %0d: got addr=%03h i=%0d d=%03h ccen=%b cc=%b rld=%b ci=%b ctl=%0d ack=%b busy=%b halted=%b err=%b / expected addr=%03h i=%0d d=%03h ccen=%b cc=%b rld=%b ci=%b ctl=%0d ack=%b busy=%b halted=%b err=%b",
                     txn, mon_a.addr, mon_a.i, mon_a.d, mon_a.ccen_b, mon_a.cc_b, mon_a.rld_b,
                     mon_a.ci, mon_a.ctl, mon_a.ack, mon_a.busy, mon_a.halted, mon_a.stk_err,
                     mon_e.addr, mon_e.i, mon_e.d, mon_e.ccen_b, mon_e.cc_b, mon_e.rld_b,
                     mon_e.ci, mon_e.ctl, mon_e.ack, mon_e.busy, mon_e.halted, mon_e.stk_err);
         end else begin
            $display("txn %0d addr=%03h i=%0d ack=%b busy=%b halted=%b err=%b ok",
                     txn, mon_a.addr, mon_a.i, mon_a.ack, mon_a.busy, mon_a.halted, mon_a.stk_err);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("check %s = %0h ok", nm, act);
      end
   endtask

   task automatic begin_cyc();
      eval_push();
      #2;
   endtask

   task automatic end_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      begin_cyc();
      end_cyc();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; halt_req = 1'b0; irq_req = 1'b0;
      full_force = 1'b0; cond_in = 8'h00; irq_vec = 12'h000;
      for (int a = 0; a < 4096; a++)
         rom[a] = mk(4'd14, 12'h000, 3'd0, 1'b0, 1'b1, 1'b1, 2'(a));
      rom[0]      = mk(4'd14, 12'h000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd2);
      rom[1]      = mk(4'd3,  12'h040, 3'd5, 1'b0, 1'b0, 1'b1, 2'd1);
      rom[12'h040] = mk(4'd4, 12'h000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0);
      rom[12'h300] = mk(4'd10, 12'h000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd3);
      @(posedge clk);
      #1;

      // reset and idle
      begin_cyc(); lit("rst_busy", 32'(busy), 0); lit("rst_seq_i", 32'(seq_i), 0); end_cyc();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // start; condition true takes the CJP
      cond_in = 8'h20;
      start = 1'b1;
      begin_cyc(); lit("idle_addr", 32'(rom_addr), 0); end_cyc();
      start = 1'b0;
      begin_cyc(); lit("fetch_busy", 32'(busy), 1); end_cyc();
      begin_cyc(); lit("r1_seq_i", 32'(seq_i), 14); lit("r1_ctl", 32'(ctl_out), 2);
                   lit("r1_addr", 32'(rom_addr), 0); end_cyc();
      begin_cyc(); lit("r2_addr", 32'(rom_addr), 1); end_cyc();
      begin_cyc(); lit("cc_bar_true", 32'(seq_cc_bar), 0);
                   lit("cjp_taken_addr", 32'(rom_addr), 12'h040); end_cyc();

      // stack guard on PUSH with a full stack
      full_force = 1'b1;
      begin_cyc(); lit("guard_seq_i", 32'(seq_i), 14); lit("guard_ci", 32'(seq_ci), 0); end_cyc();
      full_force = 1'b0;
      for (int k = 0; k < 3; k++) begin
         begin_cyc();
         lit("halt_flag", 32'(halted), 1);
         lit("halt_stk_err", 32'(stk_err), 1);
         lit("halt_addr", 32'(rom_addr), 12'h041);
         end_cyc();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      cond_in = 8'h00;
      begin_cyc(); lit("restart_addr", 32'(rom_addr), 0); lit("restart_stk_err", 32'(stk_err), 0); end_cyc();
      tick();
      tick();

      // condition false falls through; interrupt on a non-CONT is deferred
      irq_req = 1'b1;
      irq_vec = 12'h300;
      begin_cyc(); lit("cc_bar_false", 32'(seq_cc_bar), 1);
                   lit("cjp_fall_addr", 32'(rom_addr), 2);
                   lit("irq_deferred_ack", 32'(irq_ack), 0); end_cyc();
      irq_req = 1'b0;
      for (int k = 0; k < 14; k++) tick();

      // interrupt taken at the CONT fetched from 0x010
      irq_req = 1'b1;
      begin_cyc(); lit("irq_ack", 32'(irq_ack), 1); lit("irq_addr", 32'(rom_addr), 12'h300); end_cyc();
      irq_req = 1'b0;
      begin_cyc(); lit("irq_ack_pulse", 32'(irq_ack), 0); lit("crtn_addr", 32'(rom_addr), 12'h011); end_cyc();

      // halt beats interrupt
      halt_req = 1'b1;
      irq_req  = 1'b1;
      begin_cyc(); lit("halt_vs_irq_ack", 32'(irq_ack), 0); end_cyc();
      halt_req = 1'b0;
      irq_req  = 1'b0;
      begin_cyc(); lit("halt_after_halt_req", 32'(halted), 1); end_cyc();

      // reset during an interrupt cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      irq_req = 1'b1;
      rst     = 1'b1;
      begin_cyc(); lit("rst_irq_ack", 32'(irq_ack), 0); end_cyc();
      irq_req = 1'b0;
      rst     = 1'b0;
      begin_cyc(); lit("post_rst_seq_i", 32'(seq_i), 0); lit("post_rst_busy", 32'(busy), 0);
                   lit("post_rst_ack", 32'(irq_ack), 0); end_cyc();

      // randomized microprograms and control inputs
      for (int a = 0; a < 4096; a++) rom[a] = 24'($urandom);
      for (int c = 0; c < 1500; c++) begin
         rst        = ($urandom_range(0, 99) == 0);
         start      = ($urandom_range(0, 99) < 8);
         halt_req   = ($urandom_range(0, 99) < 3);
         irq_req    = ($urandom_range(0, 99) < 25);
         full_force = ($urandom_range(0, 99) < 4);
         irq_vec    = 12'($urandom);
         cond_in    = 8'($urandom);
         tick();
      end
      rst = 1'b0; start = 1'b0; halt_req = 1'b0; irq_req = 1'b0; full_force = 1'b0;
      tick();
      @(negedge clk);
      #1;
      lit("scoreboard_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
